// File: rtl/grace_pkg.sv
// Shared constants for grace_reg_bank: register address map, unmapped-read value, FSM states.
package grace_pkg;

  localparam logic [11:0] ADDR_ID      = 12'h000;
  localparam logic [11:0] ADDR_SCRATCH = 12'h001;
  localparam logic [11:0] ADDR_CTRL    = 12'h002;
  localparam logic [11:0] ADDR_STATUS  = 12'h003;
  localparam logic [11:0] ADDR_WR_CNT  = 12'h004;
  localparam logic [11:0] ADDR_RD_CNT  = 12'h005;
  localparam logic [11:0] ADDR_ERR_CNT = 12'h006;

  // GP0..GP7 occupy 0x010..0x017: match on address bits [11:3].
  localparam logic [8:0]  ADDR_GP_BASE = 9'h002;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/grace_reg_bank.sv
// Register bank on a CS/WR handshake bus; Grace_Ac pulses WAIT_CYCLES+1 cycles after CS is first sampled high.
// No backpressure: CS must drop for a cycle between transactions. Define GRACE_ERR_CNT_EN to add ERR_CNT at 0x006.
module grace_reg_bank
  import grace_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h4752_0001
) (
  input  logic        Grace_Ck,
  input  logic        Grace_Rs,
  input  logic        Grace_CS,
  input  logic        Grace_WR,
  input  logic [11:0] Grace_Ad,
  input  logic [31:0] Grace_WD,
  output logic [31:0] Grace_RD,
  output logic        Grace_Ac,
  output logic [31:0] ctrl_o,
  input  logic [31:0] status_i
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [11:0] ad_q, ad_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;
  logic        ac_q, ac_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] gp_q [8];
  logic [31:0] gp_d [8];
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
`ifdef GRACE_ERR_CNT_EN
  logic [31:0] err_cnt_q, err_cnt_d;
`endif

  logic        is_gp;
  logic [2:0]  gp_idx;
  logic        is_mapped;
  logic        is_rw;
  logic [31:0] rdata;

  assign is_gp  = (ad_q[11:3] == ADDR_GP_BASE);
  assign gp_idx = ad_q[2:0];

  // Decode of the captured address; counters read their pre-increment value.
  always_comb begin
    rdata     = UNMAPPED_RDATA;
    is_mapped = 1'b1;
    is_rw     = 1'b0;
    case (ad_q)
      ADDR_ID:      rdata = ID_VALUE;
      ADDR_SCRATCH: begin rdata = scratch_q; is_rw = 1'b1; end
      ADDR_CTRL:    begin rdata = ctrl_q;    is_rw = 1'b1; end
      ADDR_STATUS:  rdata = status_i;
      ADDR_WR_CNT:  rdata = wr_cnt_q;
      ADDR_RD_CNT:  rdata = rd_cnt_q;
`ifdef GRACE_ERR_CNT_EN
      ADDR_ERR_CNT: rdata = err_cnt_q;
`endif
      default: begin
        if (is_gp) begin
          rdata = gp_q[gp_idx];
          is_rw = 1'b1;
        end else begin
          is_mapped = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    ad_d      = ad_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    ac_d      = 1'b0;
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    gp_d      = gp_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
`ifdef GRACE_ERR_CNT_EN
    err_cnt_d = err_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (Grace_CS) begin
          wr_d    = Grace_WR;
          ad_d    = Grace_Ad;
          wd_d    = Grace_WD;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        ac_d    = 1'b1;
        state_d = ST_HOLD;
        if (wr_q) begin
          wr_cnt_d = wr_cnt_q + 32'd1;
          case (ad_q)
            ADDR_SCRATCH: scratch_d = wd_q;
            ADDR_CTRL:    ctrl_d    = wd_q;
            default:      if (is_gp) gp_d[gp_idx] = wd_q;
          endcase
        end else begin
          rd_cnt_d = rd_cnt_q + 32'd1;
          rd_d     = rdata;
        end
`ifdef GRACE_ERR_CNT_EN
        if (!is_mapped || (wr_q && !is_rw)) begin
          err_cnt_d = err_cnt_q + 32'd1;
        end
`endif
      end
      ST_HOLD: begin
        if (!Grace_CS) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Grace_Ck) begin
    if (Grace_Rs) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      ad_q      <= 12'd0;
      wd_q      <= 32'd0;
      rd_q      <= 32'd0;
      ac_q      <= 1'b0;
      scratch_q <= 32'd0;
      ctrl_q    <= 32'd0;
      for (int i = 0; i < 8; i++) gp_q[i] <= 32'd0;
      wr_cnt_q  <= 32'd0;
      rd_cnt_q  <= 32'd0;
`ifdef GRACE_ERR_CNT_EN
      err_cnt_q <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      ad_q      <= ad_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
      ac_q      <= ac_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      for (int i = 0; i < 8; i++) gp_q[i] <= gp_d[i];
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
`ifdef GRACE_ERR_CNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  assign Grace_RD = rd_q;
  assign Grace_Ac = ac_q;
  assign ctrl_o   = ctrl_q;

endmodule

// File: tb/tb_grace_reg_bank.sv
// Directed bench for grace_reg_bank: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_grace_reg_bank;

  logic        clk = 1'b0;
  logic        rs;
  logic        cs_a, cs_b;
  logic        wr;
  logic [11:0] ad;
  logic [31:0] wd;
  logic [31:0] status;
  logic [31:0] rd_a, rd_b, ctrl_a, ctrl_b;
  logic        ac_a, ac_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grace_reg_bank #(.WAIT_CYCLES(2)) u_dut_a (
    .Grace_Ck(clk), .Grace_Rs(rs), .Grace_CS(cs_a), .Grace_WR(wr),
    .Grace_Ad(ad), .Grace_WD(wd), .Grace_RD(rd_a), .Grace_Ac(ac_a),
    .ctrl_o(ctrl_a), .status_i(status)
  );

  grace_reg_bank #(.WAIT_CYCLES(0)) u_dut_b (
    .Grace_Ck(clk), .Grace_Rs(rs), .Grace_CS(cs_b), .Grace_WR(wr),
    .Grace_Ad(ad), .Grace_WD(wd), .Grace_RD(rd_b), .Grace_Ac(ac_b),
    .ctrl_o(ctrl_b), .status_i(status)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction; lat counts clock edges from the edge that samples CS high to the Ac edge.
  task automatic xfer(input bit sel, input bit w, input logic [11:0] a, input logic [31:0] d,
                      output logic [31:0] rdv, output int lat);
    wr = w; ad = a; wd = d;
    if (sel) cs_b = 1'b1; else cs_a = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!(sel ? ac_b : ac_a) && lat <= 20) begin
      lat++;
      @(negedge clk);
    end
    rdv = sel ? rd_b : rd_a;
    cs_a = 1'b0; cs_b = 1'b0;
    @(negedge clk);
    chk("ac_pulse", {31'd0, sel ? ac_b : ac_a}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    int          n_ac;
    bit          found;

    rs = 1'b1; cs_a = 1'b0; cs_b = 1'b0; wr = 1'b0; ad = '0; wd = '0;
    status = 32'h0BAD_F00D;
    repeat (2) @(negedge clk);
    rs = 1'b0;
    @(negedge clk);
    chk("rst_ac", {31'd0, ac_a}, 32'd0);
    chk("rst_rd", rd_a, 32'd0);
    chk("rst_ctrl", ctrl_a, 32'd0);

    xfer(0, 0, 12'h000, '0, r, lat);
    chk("id_lat", lat, 3);
    chk("id_rd", r, 32'h4752_0001);
    xfer(0, 0, 12'h005, '0, r, lat);
    chk("rd_cnt_1", r, 32'd1);

    xfer(0, 1, 12'h002, 32'h1234_5678, r, lat);
    chk("ctrl_wr_lat", lat, 3);
    chk("ctrl_o", ctrl_a, 32'h1234_5678);
    chk("wr_keeps_rd", r, 32'd1);
    xfer(0, 0, 12'h002, '0, r, lat);
    chk("ctrl_rd", r, 32'h1234_5678);

    xfer(0, 1, 12'h000, 32'hFFFF_FFFF, r, lat);
    xfer(0, 0, 12'h000, '0, r, lat);
    chk("id_ro", r, 32'h4752_0001);
    xfer(0, 0, 12'h07F, '0, r, lat);
    chk("unmapped", r, 32'hDEAD_BEEF);
    xfer(0, 0, 12'h006, '0, r, lat);
`ifdef GRACE_ERR_CNT_EN
    chk("err_cnt", r, 32'd2);
`else
    chk("addr6_unmapped", r, 32'hDEAD_BEEF);
`endif

    xfer(0, 1, 12'h001, 32'h55AA_33CC, r, lat);
    xfer(0, 0, 12'h001, '0, r, lat);
    chk("scratch", r, 32'h55AA_33CC);
    xfer(0, 0, 12'h003, '0, r, lat);
    chk("status", r, 32'h0BAD_F00D);
    xfer(0, 0, 12'h004, '0, r, lat);
    chk("wr_cnt_3", r, 32'd3);

    // CS held high after the acknowledge must not start another transaction.
    wr = 1'b0; ad = 12'h000; cs_a = 1'b1;
    n_ac = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (ac_a) n_ac++;
    end
    chk("hold_one_ac", n_ac, 1);
    cs_a = 1'b0;
    @(negedge clk);
    cs_a = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (ac_a) found = 1'b1;
    end
    chk("hold_reack", {31'd0, found}, 32'd1);
    cs_a = 1'b0;
    @(negedge clk);

    // Reset while the write is still waiting aborts it.
    wr = 1'b1; ad = 12'h001; wd = 32'hA5A5_A5A5; cs_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rs = 1'b1; cs_a = 1'b0;
    @(negedge clk);
    chk("abort_ac0", {31'd0, ac_a}, 32'd0);
    rs = 1'b0;
    @(negedge clk);
    chk("abort_ac1", {31'd0, ac_a}, 32'd0);
    @(negedge clk);
    chk("abort_ac2", {31'd0, ac_a}, 32'd0);
    xfer(0, 0, 12'h001, '0, r, lat);
    chk("abort_scratch", r, 32'd0);
    xfer(0, 0, 12'h004, '0, r, lat);
    chk("abort_wr_cnt", r, 32'd0);

    // Zero-wait instance: eight GP writes, each one CS-low cycle apart.
    for (int i = 0; i < 8; i++) begin
      xfer(1, 1, 12'h010 + 12'(i), 32'hC0DE_0000 | 32'(i * 32'h0101), r, lat);
      chk($sformatf("gp%0d_lat", i), lat, 1);
    end
    for (int i = 0; i < 8; i++) begin
      xfer(1, 0, 12'h010 + 12'(i), '0, r, lat);
      chk($sformatf("gp%0d_rd", i), r, 32'hC0DE_0000 | 32'(i * 32'h0101));
    end
    xfer(1, 0, 12'h004, '0, r, lat);
    chk("gp_wr_cnt", r, 32'd8);
    chk("b_ctrl", ctrl_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
